// File: rtl/traffic_light_controller.sv
// Fixed-time two-way intersection controller.
// Cycles NS green -> NS yellow -> all red -> EW green -> EW yellow -> all red,
// with each state held for its configured number of clock cycles.
module traffic_light_controller #(
  parameter int unsigned GREEN_TIME   = 5,
  parameter int unsigned YELLOW_TIME  = 2,
  parameter int unsigned ALL_RED_TIME = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned LGT_W = 2;

  // Terminal counter values: a state lasting N cycles ends when the count hits N-1.
  localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TIME - 1);

  localparam logic [LGT_W-1:0] LGT_RED    = LGT_W'(2'b00);
  localparam logic [LGT_W-1:0] LGT_YELLOW = LGT_W'(2'b01);
  localparam logic [LGT_W-1:0] LGT_GREEN  = LGT_W'(2'b10);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and dwell counter registers; reset lands in NS green with a cleared count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NS_GREEN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: count up, advance and clear the count on the last cycle of a state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      NS_GREEN: begin
        if (cnt_q == GREEN_LAST) begin
          state_d = NS_YELLOW;
          cnt_d   = '0;
        end
      end
      NS_YELLOW: begin
        if (cnt_q == YELLOW_LAST) begin
          state_d = ALL_RED_1;
          cnt_d   = '0;
        end
      end
      ALL_RED_1: begin
        if (cnt_q == ALL_RED_LAST) begin
          state_d = EW_GREEN;
          cnt_d   = '0;
        end
      end
      EW_GREEN: begin
        if (cnt_q == GREEN_LAST) begin
          state_d = EW_YELLOW;
          cnt_d   = '0;
        end
      end
      EW_YELLOW: begin
        if (cnt_q == YELLOW_LAST) begin
          state_d = ALL_RED_2;
          cnt_d   = '0;
        end
      end
      ALL_RED_2: begin
        if (cnt_q == ALL_RED_LAST) begin
          state_d = NS_GREEN;
          cnt_d   = '0;
        end
      end
      // Unused encodings recover through the all-red state before NS green.
      default: begin
        state_d = ALL_RED_2;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore decode of the lamp heads from the state register; unknown states show all red.
  always_comb begin
    ns_light = LGT_RED;
    ew_light = LGT_RED;
    case (state_q)
      NS_GREEN:  ns_light = LGT_GREEN;
      NS_YELLOW: ns_light = LGT_YELLOW;
      EW_GREEN:  ew_light = LGT_GREEN;
      EW_YELLOW: ew_light = LGT_YELLOW;
      default: begin
        ns_light = LGT_RED;
        ew_light = LGT_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench: a phase-table model indexed by edges-since-reset is
// compared against four controller instances every cycle, plus literal pins.
module tb_traffic_light_controller;

  logic clk = 1'b0;
  logic rst_def = 1'b1;
  logic rst_min = 1'b1;
  logic rst_swp = 1'b1;
  logic sweep_done = 1'b0;

  logic [1:0] ns_def, ew_def, ns_min, ew_min, ns_sa, ew_sa, ns_sb, ew_sb;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  traffic_light_controller u_def (
    .clk(clk), .reset(rst_def), .ns_light(ns_def), .ew_light(ew_def));

  traffic_light_controller #(.GREEN_TIME(1), .YELLOW_TIME(1), .ALL_RED_TIME(1)) u_min (
    .clk(clk), .reset(rst_min), .ns_light(ns_min), .ew_light(ew_min));

  traffic_light_controller #(.GREEN_TIME(3), .YELLOW_TIME(8), .ALL_RED_TIME(2)) u_sa (
    .clk(clk), .reset(rst_swp), .ns_light(ns_sa), .ew_light(ew_sa));

  traffic_light_controller #(.GREEN_TIME(8), .YELLOW_TIME(1), .ALL_RED_TIME(5)) u_sb (
    .clk(clk), .reset(rst_swp), .ns_light(ns_sb), .ew_light(ew_sb));

  // Expected {ns,ew} after n un-reset edges: walk the six-phase duration table.
  function automatic logic [3:0] model(int unsigned n, int unsigned g, int unsigned y,
                                       int unsigned r);
    int unsigned d[6];
    int unsigned p;
    d = '{g, y, r, g, y, r};
    p = n % (2 * (g + y + r));
    for (int i = 0; i < 6; i++) begin
      if (p < d[i]) begin
        case (i)
          0: return 4'b1000;
          1: return 4'b0100;
          3: return 4'b0010;
          4: return 4'b0001;
          default: return 4'b0000;
        endcase
      end
      p = p - d[i];
    end
    return 4'b1111;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got ns/ew=%b/%b want %b/%b at %0t",
                  name, act[3:2], act[1:0], exp[3:2], exp[1:0], $time);
  endtask

  function automatic logic [3:0] safe(logic [1:0] ns, logic [1:0] ew);
    return {3'b000, (ns != 2'b11) && (ew != 2'b11) && ((ns == 2'b00) || (ew == 2'b00))};
  endfunction

  // Edges seen with reset low since the last reset assertion, per reset domain.
  int unsigned n_def = 0, n_min = 0, n_swp = 0;
  always @(posedge clk or posedge rst_def) if (rst_def) n_def <= 0; else n_def <= n_def + 1;
  always @(posedge clk or posedge rst_min) if (rst_min) n_min <= 0; else n_min <= n_min + 1;
  always @(posedge clk or posedge rst_swp) if (rst_swp) n_swp <= 0; else n_swp <= n_swp + 1;

  // Per-cycle compare of every instance against the model, plus the safety invariant.
  always @(negedge clk) begin
    chk("model_def", {ns_def, ew_def}, model(n_def, 5, 2, 1));
    chk("model_min", {ns_min, ew_min}, model(n_min, 1, 1, 1));
    chk("model_sa",  {ns_sa, ew_sa},   model(n_swp, 3, 8, 2));
    chk("model_sb",  {ns_sb, ew_sb},   model(n_swp, 8, 1, 5));
    chk("safe_def", safe(ns_def, ew_def), 4'b0001);
    chk("safe_min", safe(ns_min, ew_min), 4'b0001);
    chk("safe_sa",  safe(ns_sa, ew_sa),   4'b0001);
    chk("safe_sb",  safe(ns_sb, ew_sb),   4'b0001);
  end

  // Sweep instances: random asynchronous reset pulses landing between edges.
  initial begin
    #17 rst_swp = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      if ($urandom_range(0, 59) == 0) begin
        #($urandom_range(1, 3)) rst_swp = 1'b1;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #3 rst_swp = 1'b0;
      end
    end
    sweep_done = 1'b1;
  end

  // Directed literal checks on the default and minimum-duration instances.
  initial begin
    logic [3:0] min_seq[6];
    min_seq = '{4'b0100, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 4'b1000};
    #3;
    chk("reset_def", {ns_def, ew_def}, 4'b1000);
    chk("reset_min", {ns_min, ew_min}, 4'b1000);
    @(posedge clk);          // edge at t=5 while reset high: no effect
    #1 chk("edge_in_reset", {ns_def, ew_def}, 4'b1000);
    #11 rst_def = 1'b0;      // release at t=17
    rst_min = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      @(posedge clk);
      #1;
      if (k <= 4)  chk("def_green_hold", {ns_def, ew_def}, 4'b1000);
      if (k == 5)  chk("def_edge5",  {ns_def, ew_def}, 4'b0100);
      if (k == 7)  chk("def_edge7",  {ns_def, ew_def}, 4'b0000);
      if (k == 8)  chk("def_edge8",  {ns_def, ew_def}, 4'b0010);
      if (k == 13) chk("def_edge13", {ns_def, ew_def}, 4'b0001);
      if (k == 15) chk("def_edge15", {ns_def, ew_def}, 4'b0000);
      if (k >= 16 && k <= 20) chk("def_wrap", {ns_def, ew_def}, 4'b1000);
      if (k == 29) chk("def_ew_yellow", {ns_def, ew_def}, 4'b0001);
      if (k <= 12) chk("min_seq", {ns_min, ew_min}, min_seq[(k - 1) % 6]);
    end
    // Asynchronous reset in EW yellow: outputs must snap to NS green before any edge.
    #2 rst_def = 1'b1;
    #1 chk("async_reset", {ns_def, ew_def}, 4'b1000);
    @(posedge clk);
    #1 chk("reset_hold_edge", {ns_def, ew_def}, 4'b1000);
    #2 rst_def = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k <= 4) chk("post_reset_green", {ns_def, ew_def}, 4'b1000);
      else        chk("post_reset_yellow", {ns_def, ew_def}, 4'b0100);
    end
    for (int c = 0; c < 3000 && !sweep_done; c++) @(posedge clk);
    checks++;
    if (sweep_done) passes++;
    else $display("FAIL sweep_timeout: sweep_done=%0b want 1", sweep_done);
    @(posedge clk);
    #1 $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
